fe_mul_arbiter: RTL and testbench

- Round-robin arbiter that shares one sequential field multiplier (start/done handshake, 320-bit signed limb-packed operands) among up to N_REQ requesters, such as parallel exponentiation, inversion and point-arithmetic sequencers.
- Latches the winner's operands and issues a single start pulse.
- Waits for done, then routes the product back to the winner with a one-cycle response pulse.
- Squaring requests are served on the same multiplier by driving both operands with the same value.
- A watchdog aborts a hung operation with an error response.

---
 rtl/fe_mul_arbiter.sv | 143 ++++++++++++++
 tb/tb_fe_mul_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_mul_arbiter.sv
// fe_mul_arbiter: round-robin share of one sequential field multiplier.
// Ports: req_* (N_REQ requesters), rsp_* (one-hot reply), mul_* (multiplier).
module fe_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 320,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_sq,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               mul_start,
  output logic [W-1:0]       mul_f,
  output logic [W-1:0]       mul_g,
  input  logic [W-1:0]       mul_h,
  input  logic               mul_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t           state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       grant_q, grant_d;
  logic [W-1:0]     f_q, f_d;
  logic [W-1:0]     g_q, g_d;
  logic [W-1:0]     data_q, data_d;
  logic [N_REQ-1:0] vld_q, vld_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [2:0]       win;
  logic             found;
  logic [N_REQ-1:0] grant_oh;

  // First pending requester strictly after the last winner, wrapping.
  always_comb begin
    int idx;
    win   = last_q;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  assign grant_oh = ONE << grant_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    f_d     = f_q;
    g_d     = g_q;
    data_d  = data_q;
    vld_d   = '0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          f_d     = req_a[int'(win)*W +: W];
          g_d     = req_sq[win] ? req_a[int'(win)*W +: W]
                                : req_b[int'(win)*W +: W];
          grant_d = win;
          last_d  = win;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          data_d  = mul_h;
          vld_d   = grant_oh;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: rsp_data keeps the last good product.
          vld_d   = grant_oh;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 3'(N_REQ - 1);
      grant_q <= '0;
      f_q     <= '0;
      g_q     <= '0;
      data_q  <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      f_q     <= f_d;
      g_q     <= g_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == S_ISSUE) ? grant_oh : '0;
  assign mul_start = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = vld_q;
  assign rsp_err   = err_q;
  assign rsp_data  = data_q;
  assign grant_id  = grant_q;
  assign mul_f     = f_q;
  assign mul_g     = g_q;

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// tb_fe_mul_arbiter: scoreboard bench for fe_mul_arbiter.
// Drives requesters, models a latency-L multiplier, checks replies.
module tb_fe_mul_arbiter;
  localparam int N  = 4;
  localparam int W  = 320;
  localparam int TO = 20;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_sq;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_data, mul_f, mul_g;
  logic [W-1:0]   mul_h = '0;
  logic           mul_done = 1'b0;
  logic           rsp_err, busy, mul_start;
  logic [2:0]     grant_id;

  always #5 clk = ~clk;

  fe_mul_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_sq(req_sq),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy),
    .mul_start(mul_start), .mul_f(mul_f), .mul_g(mul_g),
    .mul_h(mul_h), .mul_done(mul_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic post(input int i, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sq);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sq[i]       = sq;
    req_valid[i]    = 1'b1;
  endtask

  // Multiplier model: done arrives L cycles after the cycle following start.
  int           lat_sel = 10;
  bit           hang_sel = 1'b0;
  bit           rand_mode = 1'b0;
  int           cur_lat = 10;
  bit           cur_hang = 1'b0;
  int           mcnt = 0;
  logic [W-1:0] mres = '0;
  bit           late_req = 1'b0;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (mul_start) begin
      mcnt <= cur_hang ? 0 : cur_lat;
      mres <= mul_f * mul_g;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mul_done <= 1'b1;
        mul_h    <= mres;
      end
    end
    if (late_req) begin
      mul_done <= 1'b1;
      mul_h    <= '1;
    end
  end

  typedef struct {
    int           id;
    logic [W-1:0] data;
    bit           err;
    int           cyc;
  } exp_t;

  exp_t         sbq[$];
  int           last_m = N - 1;
  logic [W-1:0] last_data = '0;
  int           grants[$];
  int           icyc[$];
  int           rcyc[$];
  int           nrsp = 0;
  bit           repost = 1'b0;
  bit           auto_en = 1'b0;

  // Monitor: reference round-robin on grants, scoreboard on replies.
  initial begin
    int           win;
    int           idx;
    logic [W-1:0] a, g;
    exp_t         e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (req_ready != '0 || mul_start) begin
          win = -1;
          for (int k = 1; k <= N; k++) begin
            idx = (last_m + k) % N;
            if (win < 0 && req_valid[idx]) win = idx;
          end
          if (win < 0) begin
            checks++;
            failures++;
            $display("FAIL arb_none: ready %0h with no pending", req_ready);
          end else begin
            last_m = win;
            a = req_a[win*W +: W];
            g = req_sq[win] ? a : req_b[win*W +: W];
            chk("req_ready", W'(req_ready), W'(1) << win);
            chk("mul_start", W'(mul_start), W'(1));
            chk("grant_id", W'(grant_id), W'(win));
            chk("mul_f", mul_f, a);
            chk("mul_g", mul_g, g);
            if (rand_mode) begin
              cur_lat  = $urandom_range(1, 15);
              cur_hang = ($urandom_range(0, 9) == 0);
            end else begin
              cur_lat  = lat_sel;
              cur_hang = hang_sel;
            end
            e.id   = win;
            e.data = a * g;
            e.err  = cur_hang;
            e.cyc  = cyc + (cur_hang ? TO + 1 : cur_lat + 2);
            sbq.push_back(e);
            grants.push_back(win);
            icyc.push_back(cyc);
          end
        end
        if (rsp_valid != '0) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexp: rsp_valid %0h, none expected",
                     rsp_valid);
          end else begin
            e = sbq.pop_front();
            chk("rsp_valid", W'(rsp_valid), W'(1) << e.id);
            chk("rsp_err", W'(rsp_err), W'(e.err));
            chk("rsp_data", rsp_data, e.err ? last_data : e.data);
            chk("rsp_cycle", W'(cyc), W'(e.cyc));
            if (!e.err) last_data = e.data;
          end
          nrsp++;
          rcyc.push_back(cyc);
        end
      end
    end
  end

  // Requesters drop valid after accept; optionally re-request.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] === 1'b1) begin
          req_valid[i] = 1'b0;
          if (repost) post(i, rnd(), rnd(), 1'b0);
        end else if (auto_en && !req_valid[i] &&
                     $urandom_range(0, 3) == 0) begin
          post(i, rnd(), rnd(), 1'($urandom_range(0, 1)));
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, W'(req_ready), '0);
    chk({tag, "_rspv"}, W'(rsp_valid), '0);
    chk({tag, "_data"}, rsp_data, '0);
    chk({tag, "_err"}, W'(rsp_err), '0);
    chk({tag, "_gid"}, W'(grant_id), '0);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_start"}, W'(mul_start), '0);
    chk({tag, "_f"}, mul_f, '0);
    chk({tag, "_g"}, mul_g, '0);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (nrsp < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (nrsp < n) begin
      failures++;
      $display("FAIL wait_rsp: got %0d responses want %0d", nrsp, n);
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sbq.size() != 0 || req_valid != '0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sbq.size() != 0 || req_valid != '0 || busy) begin
      failures++;
      $display("FAIL drain: %0d outstanding", sbq.size());
    end
  endtask

  task automatic flush_model();
    sbq.delete();
    last_m    = N - 1;
    last_data = '0;
    req_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int g0, r0, n0, k;
    reset = 1'b1;
    req_valid = '0;
    req_sq = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;

    // single multiply on requester 2
    @(negedge clk);
    post(2, 5, 7, 1'b0);
    wait_rsp(1, 40);
    chk("single_data", last_data, W'(35));

    // square on requester 0
    post(0, 9, 3, 1'b1);
    wait_rsp(2, 40);
    chk("square_data", last_data, W'(81));

    // contention from reset
    do_reset();
    g0 = grants.size();
    r0 = rcyc.size();
    repost = 1'b1;
    for (int i = 0; i < N; i++) post(i, rnd(), rnd(), 1'b0);
    k = 0;
    while (grants.size() < g0 + 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repost = 1'b0;
    drain(400);
    checks++;
    if (grants.size() < g0 + 5 || rcyc.size() < r0 + 4) begin
      failures++;
      $display("FAIL contention: only %0d grants", grants.size() - g0);
    end else begin
      for (int j = 0; j < 5; j++)
        chk("cont_order", W'(grants[g0+j]), W'(j % N));
      for (int j = 0; j < 4; j++)
        chk("cont_gap", W'(icyc[g0+j+1]), W'(rcyc[r0+j] + 1));
    end

    // timeout, then a stale done in IDLE, then a normal op
    hang_sel = 1'b1;
    n0 = nrsp;
    post(1, 11, 13, 1'b0);
    wait_rsp(n0 + 1, 60);
    hang_sel = 1'b0;
    @(negedge clk);
    late_req = 1'b1;
    @(negedge clk);
    late_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("late_ignored", W'(nrsp), W'(n0 + 1));
    post(3, 6, 4, 1'b0);
    wait_rsp(n0 + 2, 40);
    chk("after_to", last_data, W'(24));

    // reset four cycles into WAIT
    lat_sel = 12;
    g0 = icyc.size();
    post(3, 8, 8, 1'b0);
    k = 0;
    while (icyc.size() == g0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("midrst");
    flush_model();
    @(negedge clk);
    reset = 1'b0;
    n0 = nrsp;
    repeat (20) @(negedge clk);
    chk("no_rsp_after_rst", W'(nrsp), W'(n0));
    lat_sel = 10;
    g0 = grants.size();
    post(0, 3, 5, 1'b0);
    post(2, 7, 2, 1'b0);
    wait_rsp(n0 + 2, 80);
    if (grants.size() >= g0 + 2) begin
      chk("rst_first", W'(grants[g0]), W'(0));
      chk("rst_second", W'(grants[g0+1]), W'(2));
    end else begin
      checks++;
      failures++;
      $display("FAIL rst_grants: got %0d want 2", grants.size() - g0);
    end

    // randomized traffic
    rand_mode = 1'b1;
    auto_en = 1'b1;
    wait_rsp(nrsp + 60, 5000);
    auto_en = 1'b0;
    drain(400);
    rand_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
